multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I subset core. It sequences fetch, decode, execute, memory and writeback over several cycles and drives the ALU opcode (`ALUctrl`) and all datapath selects and strobes. It consumes the ALU's `EQ` flag to resolve branches and a shared-memory `mem_ready` handshake. It replaces the single-cycle combinational decoder and sits between the instruction register and the datapath.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/instr_class_dec.sv | 33 +++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// instruction fields, instruction classes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADR,
        S_MEM_RD, S_MEM_WR, S_MEM_WB, S_ALU_WB, S_BRANCH, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_ADD, C_SUB, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_ILL
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // ALU opcodes, also decoded by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier: opcode/funct3/funct7 to a class
// enum; anything outside the supported subset maps to C_ILL.
module instr_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output iclass_t    cls,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        unique case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD)      cls = C_ADD;
                else if (funct3 == F3_ADD && funct7 == F7_SUB) cls = C_SUB;
            end
            OP_IMM:    if (funct3 == F3_ADD) cls = C_ADDI;
            OP_LOAD:   if (funct3 == F3_W)   cls = C_LW;
            OP_STORE:  if (funct3 == F3_W)   cls = C_SW;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ)      cls = C_BEQ;
                else if (funct3 == F3_BNE) cls = C_BNE;
            end
            default: cls = C_ILL;
        endcase
    end

    assign illegal = (cls == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the ALU opcode, datapath selects and strobes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic            mem_ready,
    input  logic            EQ,
    output logic [2:0]      ALUctrl,
    output logic [1:0]      ALUsrcA,
    output logic [1:0]      ALUsrcB,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      ResultSrc,
    output logic            AdrSrc,
    output logic            mem_req,
    output logic            mem_we,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic            illegal
);

    state_t  state, next;
    iclass_t cls;
    logic    dec_illegal;

    instr_class_dec u_dec (
        .opcode  (instr[6:0]),
        .funct3  (instr[14:12]),
        .funct7  (instr[31:25]),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // Register/immediate fields belong to the datapath, not the controller
    logic unused_bits;
    assign unused_bits = ^{instr[24:15], instr[11:7], dec_illegal};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_RESET:  next = S_FETCH;
            S_FETCH:  if (mem_ready) next = S_DECODE;
            S_DECODE: begin
                unique case (cls)
                    C_ADD, C_SUB: next = S_EXEC_R;
                    C_ADDI:       next = S_EXEC_I;
                    C_LW, C_SW:   next = S_MEM_ADR;
                    C_BEQ, C_BNE: next = S_BRANCH;
                    default:      next = S_TRAP;
                endcase
            end
            S_EXEC_R:  next = S_ALU_WB;
            S_EXEC_I:  next = S_ALU_WB;
            S_MEM_ADR: next = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) next = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) next = S_FETCH;
            S_MEM_WB:  next = S_FETCH;
            S_ALU_WB:  next = S_FETCH;
            S_BRANCH:  next = S_FETCH;
            S_TRAP:    next = S_TRAP;
            default:   next = S_RESET;
        endcase
    end

    // Moore decode, plus the FETCH strobes gated by mem_ready and the
    // branch PC load gated by EQ
    always_comb begin
        ALUctrl   = ALU_ADD;
        ALUsrcA   = SRCA_PC;
        ALUsrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUsrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUsrcA = SRCA_OLDPC;
                ALUsrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_EXEC_R: begin
                ALUsrcA = SRCA_RS1;
                ALUctrl = (cls == C_SUB) ? ALU_SUB : ALU_ADD;
            end
            S_EXEC_I: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_IMM;
            end
            S_MEM_ADR: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_IMM;
                ImmSrc  = (cls == C_SW) ? IMM_S : IMM_I;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEM_WB: begin
                ResultSrc = RES_MEM;
                RegWrite  = 1'b1;
            end
            S_ALU_WB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUsrcA = SRCA_RS1;
                ALUctrl = ALU_SUB;
                PCWrite = (cls == C_BEQ && EQ) || (cls == C_BNE && !EQ);
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random
// legal instructions with random memory wait states.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        EQ = 1'b0;
    logic [2:0]  ALUctrl;
    logic [1:0]  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc;
    logic        AdrSrc, mem_req, mem_we, IRWrite, PCWrite, RegWrite, illegal;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .EQ(EQ),
        .ALUctrl(ALUctrl), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .mem_req(mem_req), .mem_we(mem_we),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {ALUctrl, ALUsrcA, ALUsrcB, ImmSrc, ResultSrc, AdrSrc, mem_req, mem_we,
    //  IRWrite, PCWrite, RegWrite, illegal}
    logic [17:0] obs;
    assign obs = {ALUctrl, ALUsrcA, ALUsrcB, ImmSrc, ResultSrc, AdrSrc, mem_req,
                  mem_we, IRWrite, PCWrite, RegWrite, illegal};

    function automatic logic [17:0] v(input logic [2:0] alu, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] imm,
                                      input logic [1:0] res, input logic adr,
                                      input logic req, input logic we, input logic irw,
                                      input logic pcw, input logic rw, input logic ill);
        return {alu, a, b, imm, res, adr, req, we, irw, pcw, rw, ill};
    endfunction

    // Class by the supported-subset rules: 0 add 1 sub 2 addi 3 lw 4 sw 5 beq 6 bne 7 illegal
    function automatic int classify(input logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return 0;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return 1;
        if (op == 7'b0010011 && f3 == 3'b000) return 2;
        if (op == 7'b0000011 && f3 == 3'b010) return 3;
        if (op == 7'b0100011 && f3 == 3'b010) return 4;
        if (op == 7'b1100011 && f3 == 3'b000) return 5;
        if (op == 7'b1100011 && f3 == 3'b001) return 6;
        return 7;
    endfunction

    function automatic logic [31:0] rand_instr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            0: return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            1: return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
            2: return {r[31:15], 3'b000, r[11:7], 7'b0010011};
            3: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            4: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            5: return {r[31:15], 3'b000, r[11:7], 7'b1100011};
            default: return {r[31:15], 3'b001, r[11:7], 7'b1100011};
        endcase
    endfunction

    // One clock cycle: inputs are already set; sample on the falling edge
    task automatic step(input logic [17:0] exp, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input logic [17:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input int waits);
        repeat (waits) begin
            mem_ready = 1'b0; EQ = 1'($urandom);
            step(v(3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0), "fetch_wait");
        end
        mem_ready = 1'b1;
        step(v(3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 1, 1, 0, 0), "fetch");
    endtask

    task automatic do_decode();
        mem_ready = 1'($urandom); EQ = 1'($urandom);
        step(v(3'd0, 2'd1, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0), "decode");
    endtask

    task automatic mem_phase(input int waits, input logic we, input string tag);
        repeat (waits) begin
            mem_ready = 1'b0; EQ = 1'($urandom);
            step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1, we, 0, 0, 0, 0), tag);
        end
        mem_ready = 1'b1;
        step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1, we, 0, 0, 0, 0), tag);
    endtask

    // Run one whole instruction starting in FETCH; eq drives the branch compare
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic eq);
        int k;
        k = classify(ins);
        instr = ins;
        do_fetch(fw);
        do_decode();
        mem_ready = 1'($urandom); EQ = 1'($urandom);
        case (k)
            0, 1: begin
                step(v((k == 1) ? 3'd1 : 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0),
                     "exec_r");
                mem_ready = 1'($urandom);
                step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), "alu_wb");
            end
            2: begin
                step(v(3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "exec_i");
                mem_ready = 1'($urandom);
                step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), "alu_wb");
            end
            3: begin
                step(v(3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "mem_adr_lw");
                mem_phase(mw, 1'b0, "mem_rd");
                mem_ready = 1'($urandom);
                step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0, 0, 0, 1, 0), "mem_wb");
            end
            4: begin
                step(v(3'd0, 2'd2, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0), "mem_adr_sw");
                mem_phase(mw, 1'b1, "mem_wr");
            end
            5, 6: begin
                EQ = eq;
                step(v(3'd1, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0,
                       (k == 5) ? eq : !eq, 0, 0), "branch");
            end
            default: begin
                repeat (4) begin
                    mem_ready = 1'($urandom); EQ = 1'($urandom);
                    step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1), "trap");
                end
            end
        endcase
    endtask

    // Pulse reset for two cycles, then check the single RESET cycle
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_now('0, "rst_async");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step('0, "reset_cycle");
    endtask

    initial begin
        #2;
        check_now('0, "reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        step('0, "reset_cycle");

        run_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
        run_instr(32'h00002103, 0, 3, 1'b0);   // lw x2,0(x0), 3 wait cycles
        run_instr(32'h00001463, 0, 0, 1'b1);   // bne, EQ=1: not taken
        run_instr(32'h00001463, 0, 0, 1'b0);   // bne, EQ=0: taken
        run_instr(32'h00000463, 1, 0, 1'b1);   // beq, EQ=1: taken
        run_instr(32'h40208033, 0, 0, 1'b0);   // sub
        run_instr(32'h00208033, 0, 0, 1'b0);   // add
        run_instr(32'h00202023, 2, 2, 1'b0);   // sw with waits

        for (int i = 0; i < 40; i++)
            run_instr(rand_instr(int'($urandom_range(6, 0))),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      1'($urandom));

        // Reset while a store is stalled in MEM_WR
        instr = 32'h00202023;
        do_fetch(0);
        do_decode();
        step(v(3'd0, 2'd2, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0), "mem_adr_sw");
        mem_ready = 1'b0;
        step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0), "mem_wr_stall");
        do_reset();
        mem_ready = 1'b1;
        step(v(3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 1, 0, 1, 1, 0, 0), "fetch_after_rst");
        instr = 32'h00500093;
        do_decode();
        step(v(3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "exec_i_after_rst");
        step(v(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0), "alu_wb_after_rst");

        run_instr(32'h000000b7, 0, 0, 1'b0);   // lui: trap
        do_reset();
        run_instr(32'h02208033, 1, 0, 1'b0);   // R-type with funct7=1: trap
        do_reset();
        run_instr(32'h00001013, 0, 0, 1'b0);   // slli (OP-IMM funct3 001): trap
        do_reset();
        run_instr(32'h00500093, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
